// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Desc     : Hazard inputs and pipeline-register controls of pipe_ctrl.
// Revision : 1.0
// ============================================================================
interface pipe_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        ex_mdu_start;
    logic        mdu_done;
    logic        pc_write;
    logic [1:0]  ifid_clear;
    logic [1:0]  idex_clear;
    logic [1:0]  exmem_clear;
    logic [1:0]  memwb_clear;
    logic [15:0] stall_cnt;
    logic        mdu_timeout;

    // Datapath side: presents ID/EX status, receives the controls.
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_mdu_start, mdu_done,
        input  pc_write, ifid_clear, idex_clear, exmem_clear, memwb_clear,
               stall_cnt, mdu_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_mdu_start, mdu_done,
        output pc_write, ifid_clear, idex_clear, exmem_clear, memwb_clear,
               stall_cnt, mdu_timeout
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Desc     : Pipeline stall/flush controller; MDU wait built with
//            `define PIPE_CTRL_MDU_EN.
// Revision : 1.0
// ============================================================================
module pipe_ctrl #(
    parameter int INIT_FLUSH  = 4,
    parameter int MDU_TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus_io
);
    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MDU_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] CLR_LOAD  = 2'b00;
    localparam logic [1:0] CLR_HOLD  = 2'b01;
    localparam logic [1:0] CLR_FLUSH = 2'b11;
    localparam logic [3:0] INIT_LAST = 4'(INIT_FLUSH - 1);

    state_t      state_q, state_d;
    logic [3:0]  init_cnt_q, init_cnt_d;
    logic        lu_q, lu_d;
    logic [15:0] stall_cnt_q;
    logic        w_load_use;
    logic        w_pc_write;
    logic [1:0]  w_ifid, w_idex, w_exmem, w_memwb;

`ifdef PIPE_CTRL_MDU_EN
    localparam logic [7:0] WAIT_LAST = 8'(MDU_TIMEOUT);
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
`else
    logic w_unused_mdu;
    assign w_unused_mdu = bus_io.ex_mdu_start ^ bus_io.mdu_done;
`endif

    assign w_load_use = bus_io.ex_mem_read && (bus_io.ex_rd != 5'd0) &&
                        ((bus_io.id_uses_rs1 && (bus_io.id_rs1 == bus_io.ex_rd)) ||
                         (bus_io.id_uses_rs2 && (bus_io.id_rs2 == bus_io.ex_rd)));

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        lu_d       = 1'b0;
        w_pc_write = 1'b0;
        w_ifid     = CLR_FLUSH;
        w_idex     = CLR_FLUSH;
        w_exmem    = CLR_FLUSH;
        w_memwb    = CLR_FLUSH;
`ifdef PIPE_CTRL_MDU_EN
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 4'd1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = ST_RUN;
                    init_cnt_d = 4'd0;
                end
            end
            ST_RUN: begin
                w_pc_write = 1'b1;
                w_ifid     = CLR_LOAD;
                w_idex     = CLR_LOAD;
                w_exmem    = CLR_LOAD;
                w_memwb    = CLR_LOAD;
                if (bus_io.ex_branch_taken) begin
                    w_ifid = CLR_FLUSH;
                    w_idex = CLR_FLUSH;
                end
`ifdef PIPE_CTRL_MDU_EN
                else if (bus_io.ex_mdu_start) begin
                    // A same-cycle result needs no wait at all.
                    if (!bus_io.mdu_done) begin
                        w_pc_write = 1'b0;
                        w_ifid     = CLR_HOLD;
                        w_idex     = CLR_HOLD;
                        w_exmem    = CLR_FLUSH;
                        state_d    = ST_MDU_WAIT;
                        wait_cnt_d = 8'd1;
                    end
                end
`endif
                // lu_q blocks a second stall while the same load is still seen in EX.
                else if (w_load_use && !lu_q) begin
                    w_pc_write = 1'b0;
                    w_ifid     = CLR_HOLD;
                    w_idex     = CLR_FLUSH;
                    lu_d       = 1'b1;
                end
            end
`ifdef PIPE_CTRL_MDU_EN
            ST_MDU_WAIT: begin
                if (bus_io.mdu_done || (wait_cnt_q == WAIT_LAST)) begin
                    w_pc_write = 1'b1;
                    w_ifid     = CLR_LOAD;
                    w_idex     = CLR_LOAD;
                    w_exmem    = CLR_LOAD;
                    w_memwb    = CLR_LOAD;
                    state_d    = ST_RUN;
                    if (!bus_io.mdu_done) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    w_ifid     = CLR_HOLD;
                    w_idex     = CLR_HOLD;
                    w_exmem    = CLR_FLUSH;
                    w_memwb    = CLR_LOAD;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
`endif
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= 4'd0;
            lu_q        <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            lu_q       <= lu_d;
            if (!w_pc_write && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

`ifdef PIPE_CTRL_MDU_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus_io.mdu_timeout = timeout_q;
`else
    assign bus_io.mdu_timeout = 1'b0;
`endif

    assign bus_io.pc_write    = w_pc_write;
    assign bus_io.ifid_clear  = w_ifid;
    assign bus_io.idex_clear  = w_idex;
    assign bus_io.exmem_clear = w_exmem;
    assign bus_io.memwb_clear = w_memwb;
    assign bus_io.stall_cnt   = stall_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Desc     : Directed scoreboard bench for pipe_ctrl (both build options).
// Revision : 1.0
// ============================================================================
module tb_pipe_ctrl;
    localparam int INIT_FLUSH  = 4;
    localparam int MDU_TIMEOUT = 40;
`ifdef PIPE_CTRL_MDU_EN
    localparam bit MDU_ON = 1'b1;
`else
    localparam bit MDU_ON = 1'b0;
`endif

    typedef struct packed {
        logic        pc;
        logic [1:0]  ifid;
        logic [1:0]  idex;
        logic [1:0]  exmem;
        logic [1:0]  memwb;
        logic [15:0] st;
        logic        to;
    } exp_t;

    logic        clk;
    logic        rst_n;
    pipe_ctrl_if bus();

    pipe_ctrl #(
        .INIT_FLUSH (INIT_FLUSH),
        .MDU_TIMEOUT(MDU_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    exp_t  sb_q[$];
    string nm_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    model_stall = 0;
    logic  to_exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr,
                         input logic br, input logic ms, input logic md);
        bus.id_rs1 = rs1;  bus.id_rs2 = rs2;
        bus.id_uses_rs1 = u1;  bus.id_uses_rs2 = u2;
        bus.ex_rd = rd;  bus.ex_mem_read = mr;
        bus.ex_branch_taken = br;  bus.ex_mdu_start = ms;  bus.mdu_done = md;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue this cycle's expected outputs, then advance one clock.
    task automatic chk(input string nm, input logic pc, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] c, input logic [1:0] d, input logic to);
        exp_t e;
        e.pc = pc;  e.ifid = a;  e.idex = b;  e.exmem = c;  e.memwb = d;
        e.st = 16'(model_stall);  e.to = to;
        sb_q.push_back(e);
        nm_q.push_back(nm);
        if (!pc && rst_n && model_stall < 65535) model_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic t_init(input string nm);           chk(nm, 1'b0, 2'b11, 2'b11, 2'b11, 2'b11, 1'b0); endtask
    task automatic t_norm(input string nm, input logic to); chk(nm, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, to); endtask
    task automatic t_ld(input string nm, input logic to);   chk(nm, 1'b0, 2'b01, 2'b11, 2'b00, 2'b00, to); endtask
    task automatic t_br(input string nm, input logic to);   chk(nm, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00, to); endtask
    task automatic t_mdu(input string nm, input logic to);  chk(nm, 1'b0, 2'b01, 2'b01, 2'b11, 2'b00, to); endtask

    // Monitor: one scoreboard entry per cycle, compared mid-cycle.
    exp_t  m_exp, m_act;
    string m_nm;
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            m_exp = sb_q.pop_front();
            m_nm  = nm_q.pop_front();
            m_act = {bus.pc_write, bus.ifid_clear, bus.idex_clear, bus.exmem_clear,
                     bus.memwb_clear, bus.stall_cnt, bus.mdu_timeout};
            n_checks++;
            if (m_act !== m_exp) begin
                n_fail++;
                $display("FAIL %s @%0t: got pc=%b if=%b id=%b ex=%b wb=%b st=%0d to=%b, want pc=%b if=%b id=%b ex=%b wb=%b st=%0d to=%b",
                         m_nm, $time, m_act.pc, m_act.ifid, m_act.idex, m_act.exmem, m_act.memwb,
                         m_act.st, m_act.to, m_exp.pc, m_exp.ifid, m_exp.idex, m_exp.exmem,
                         m_exp.memwb, m_exp.st, m_exp.to);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        model_stall = 0;
        idle();
        @(posedge clk);
        #1;

        t_init("reset_state");
        t_init("reset_state");
        rst_n = 1'b1;
        for (int i = 0; i < INIT_FLUSH; i++) t_init("init_flush");
        t_norm("run_after_init", 1'b0);
        t_norm("run_after_init", 1'b0);

        drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);  t_ld("lu_rs2", 1'b0);
        idle();                                                         t_norm("lu_rs2_next", 1'b0);
        drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);  t_ld("lu_rs1", 1'b0);
        idle();                                                         t_norm("lu_rs1_next", 1'b0);
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);  t_norm("lu_rd_zero", 1'b0);
        drive(5'd9, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);  t_norm("lu_not_used", 1'b0);
        drive(5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);  t_norm("lu_not_load", 1'b0);
        drive(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);  t_norm("lu_no_match", 1'b0);
        drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);  t_br("br_over_lu", 1'b0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);  t_br("branch", 1'b0);
        idle();                                                         t_norm("after_branch", 1'b0);

        // MDU result ten cycles after start; branch and load-use injected mid-wait.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (MDU_ON) t_mdu("mdu_start", 1'b0); else t_norm("mdu_start_ignored", 1'b0);
        for (int i = 1; i < 10; i++) begin
            idle();
            if (i == 3) bus.ex_branch_taken = 1'b1;
            if (i == 5) drive(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
            if (MDU_ON)      t_mdu("mdu_wait", 1'b0);
            else if (i == 3) t_br("nomdu_branch", 1'b0);
            else if (i == 5) t_ld("nomdu_lu", 1'b0);
            else             t_norm("nomdu_idle", 1'b0);
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);  t_norm("mdu_done", 1'b0);
        idle();                                                         t_norm("after_done", 1'b0);

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);  t_norm("mdu_same_cycle", 1'b0);
        idle();                                                         t_norm("after_same_cycle", 1'b0);

        // MDU never completes: forced exit after MDU_TIMEOUT stall cycles.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (MDU_ON) t_mdu("to_start", 1'b0); else t_norm("to_start_ignored", 1'b0);
        idle();
        for (int i = 1; i < MDU_TIMEOUT; i++) begin
            if (MDU_ON) t_mdu("to_wait", 1'b0); else t_norm("to_wait_ignored", 1'b0);
        end
        t_norm("to_exit", 1'b0);
        to_exp = MDU_ON;
        t_norm("to_flag_held", to_exp);
        t_norm("to_flag_held", to_exp);

        // Reset asserted mid-wait drops the flag and restarts INIT.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (MDU_ON) t_mdu("rw_start", to_exp); else t_norm("rw_start_ignored", to_exp);
        idle();
        if (MDU_ON) t_mdu("rw_wait", to_exp); else t_norm("rw_wait_ignored", to_exp);
        rst_n = 1'b0;
        model_stall = 0;
        t_init("rw_reset");
        t_init("rw_reset");
        rst_n = 1'b1;
        for (int i = 0; i < INIT_FLUSH; i++) t_init("rw_init_flush");
        t_norm("rw_run", 1'b0);
        t_norm("rw_run", 1'b0);

        repeat (2) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
